// File: rtl/increment_repeat_ctrl.sv
// increment_repeat_ctrl: turns held seconds/minutes buttons into single-cycle
// increment pulses for the cook-time setting counters. A press gives one
// immediate pulse, then auto-repeat after a hold delay, then a faster repeat
// rate once a set number of slow repeats has gone by. Only one button owns
// the scheduler at a time; minutes wins a simultaneous press.
module increment_repeat_ctrl #(
  parameter int HOLD_DELAY  = 500,
  parameter int SLOW_PERIOD = 200,
  parameter int FAST_PERIOD = 50,
  parameter int FAST_AFTER  = 8,
  parameter int CNT_W       = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic prog_mode,
  input  logic seconds_req,
  input  logic minutes_req,
  output logic increment_seconds,
  output logic increment_minutes,
  output logic repeating,
  output logic fast
);

  localparam int REP_W = $clog2(FAST_AFTER + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST    = CNT_W'(SLOW_PERIOD - 1);
  localparam logic [CNT_W-1:0] FAST_LAST    = CNT_W'(FAST_PERIOD - 1);
  localparam logic [REP_W-1:0] FAST_AFTER_C = REP_W'(FAST_AFTER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SLOW = 2'd2,
    FAST = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] tickCnt_q, tickCnt_d;
  logic [REP_W-1:0] repCnt_q, repCnt_d;
  logic             incSec_q, incSec_d;
  logic             incMin_q, incMin_d;
  logic             repeating_q, fast_q;

  logic [CNT_W-1:0] periodLast;
  logic             ownerReq;
  logic             expire;
  logic [REP_W-1:0] repNext;

  // Pick the terminal count for the current repeat phase and see whether this tick expires it.
  always_comb begin
    periodLast = FAST_LAST;
    case (state_q)
      HOLD:    periodLast = HOLD_LAST;
      SLOW:    periodLast = SLOW_LAST;
      default: periodLast = FAST_LAST;
    endcase
    ownerReq = owner_q ? minutes_req : seconds_req;
    expire   = tick && (tickCnt_q == periodLast);
    repNext  = repCnt_q + REP_W'(1);
  end

  // Next-state logic: accept a press from IDLE, count ticks while held, drop out on release or prog_mode loss.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    tickCnt_d = tickCnt_q;
    repCnt_d  = repCnt_q;
    incSec_d  = 1'b0;
    incMin_d  = 1'b0;

    if (state_q == IDLE) begin
      if (prog_mode && (minutes_req || seconds_req)) begin
        owner_d   = minutes_req;
        tickCnt_d = '0;
        repCnt_d  = '0;
        state_d   = HOLD;
        incMin_d  = minutes_req;
        incSec_d  = !minutes_req;
      end
    end else if (!prog_mode || !ownerReq) begin
      state_d   = IDLE;
      tickCnt_d = '0;
      repCnt_d  = '0;
    end else if (expire) begin
      tickCnt_d = '0;
      incMin_d  = owner_q;
      incSec_d  = !owner_q;
      case (state_q)
        HOLD: state_d = SLOW;
        SLOW: begin
          repCnt_d = repNext;
          if (repNext == FAST_AFTER_C) begin
            state_d = FAST;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (tick) begin
      tickCnt_d = tickCnt_q + CNT_W'(1);
    end
  end

  // State, counters and registered outputs; repeating/fast are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      tickCnt_q   <= '0;
      repCnt_q    <= '0;
      incSec_q    <= 1'b0;
      incMin_q    <= 1'b0;
      repeating_q <= 1'b0;
      fast_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      tickCnt_q   <= tickCnt_d;
      repCnt_q    <= repCnt_d;
      incSec_q    <= incSec_d;
      incMin_q    <= incMin_d;
      repeating_q <= (state_d == SLOW) || (state_d == FAST);
      fast_q      <= (state_d == FAST);
    end
  end

  assign increment_seconds = incSec_q;
  assign increment_minutes = incMin_q;
  assign repeating         = repeating_q;
  assign fast              = fast_q;

endmodule

// File: doc/increment_repeat_ctrl.md
Name: increment_repeat_ctrl

Overview:
- Scheduler for the cook-time setting counters.
- Converts held seconds/minutes buttons into single-cycle increment pulses: one immediate pulse, then auto-repeat after a hold delay, then a faster rate after a set number of repeats.
- Arbitrates between the two buttons so only one counter is driven at a time.
- Sits between the debounced button inputs and the seconds/minutes setting counters, and is gated by prog_mode from the main controller.

Parameters:
- HOLD_DELAY, 500: ticks from the first pulse until the first auto-repeat pulse (>=1).
- SLOW_PERIOD, 200: ticks between pulses in slow repeat (>=1).
- FAST_PERIOD, 50: ticks between pulses in fast repeat (>=1).
- FAST_AFTER, 8: number of slow-repeat pulses before switching to fast (>=1).
- CNT_W, 10: tick counter width; must hold max(HOLD_DELAY, SLOW_PERIOD, FAST_PERIOD).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- tick, input, 1: one-cycle timebase pulse (nominally 1 ms).
- prog_mode, input, 1: setting mode active; no pulses are issued when low.
- seconds_req, input, 1: debounced seconds button, level.
- minutes_req, input, 1: debounced minutes button, level.
- increment_seconds, output, 1: registered one-cycle increment pulse to the seconds setting counter.
- increment_minutes, output, 1: registered one-cycle increment pulse to the minutes setting counter.
- repeating, output, 1: high in SLOW or FAST states.
- fast, output, 1: high in FAST state.

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high. On reset: state IDLE, owner cleared, tick counter 0, repeat counter 0, all outputs 0.
- States: IDLE, HOLD, SLOW, FAST. The owner register selects SEC or MIN.
- IDLE:
  - If prog_mode=1 and a request is high, accept it. If both are high, minutes wins.
  - Load owner, clear both counters, go to HOLD.
  - The owner's increment pulse is high for exactly the next cycle (latency 1).
- HOLD / SLOW / FAST:
  - The tick counter increments on tick.
  - When tick=1 and count == period-1: count is cleared, and the owner pulse is high the next cycle.
  - Periods: HOLD uses HOLD_DELAY, SLOW uses SLOW_PERIOD, FAST uses FAST_PERIOD.
  - HOLD expiry goes to SLOW. This pulse is not counted toward FAST_AFTER.
  - Each SLOW expiry increments the repeat counter. The expiry that makes it equal FAST_AFTER goes to FAST.
  - The repeat counter saturates; FAST holds until exit.
- Exit, checked in any non-IDLE state:
  - If the owner request is low or prog_mode=0, go to IDLE next cycle and clear the counters.
  - Exit has priority over a same-cycle expiry: no pulse is issued.
- The non-owner request is ignored while owned.
- After returning to IDLE, any request still high is accepted by the normal IDLE rule. So releasing the owner while the other button is held yields the other's first pulse 2 cycles after the release cycle.
- increment_seconds and increment_minutes are never both high. Neither is ever high in a cycle following a cycle where prog_mode=0.
- repeating and fast are registered decodes of state; they are 0 in IDLE and HOLD.
- Counter widths: the tick counter is CNT_W bits and is compared against period-1, so it never wraps in legal configurations.
- Reset mid-operation: returns to IDLE next cycle. A pending pulse is dropped.

Test Plan:
Bench parameters: HOLD_DELAY=4, SLOW_PERIOD=3, FAST_PERIOD=1, FAST_AFTER=2, tick every 2nd clk, prog_mode=1 unless stated.
1. seconds_req high for 1 cycle -> increment_seconds high exactly 1 cycle, the cycle after; no further pulses over 50 ticks.
2. seconds_req held -> pulses at hold start, then after 4, 7, 10, 11, 12, 13 ticks. repeating rises after tick 4; fast rises after tick 10. increment_minutes stays 0.
3. seconds_req and minutes_req rise in the same cycle -> only increment_minutes pulses. minutes_req dropped at cycle n with seconds_req still held -> increment_seconds pulse in cycle n+2, then seconds repeat restarts from HOLD.
4. prog_mode dropped during FAST with minutes held -> no pulses, IDLE, repeating=fast=0. prog_mode restored with minutes still held -> immediate pulse, then the HOLD 4-tick delay again.
5. Owner release in the same cycle as the expiring tick in SLOW -> no pulse, IDLE next cycle.
6. reset asserted for 1 cycle during SLOW -> all outputs 0 from the next cycle. With seconds_req still held after reset, first pulse 2 cycles after reset deasserts, then the full HOLD_DELAY.
